axis_i2c_cfg_seq: RTL and testbench
===================================

// Module: axis_i2c_cfg_seq
// PURPOSE
//  Configuration sequencer feeding the s_axis slave port of axis_i2c_master.
//  - Walks a ROM image of 16-bit {reg_addr, reg_data} words loaded from CONFIG_MEM.
//  - Emits each data word as one AXI-Stream beat.
//  - Interprets in-band delay and end-of-table tokens.
//  - Flags completion so downstream logic (sensor/codec bring-up) can release.
//  - Runs on the divided I2C clock domain, beside axis_i2c_master.
// PARAMETERS
//  MEM_WIDTH     16                     ROM word / tdata width
//  MEM_DEPTH     24                     ROM entries; address width = $clog2(MEM_DEPTH)
//  CONFIG_MEM    "../../src/config.mem" hex image loaded via $readmemh
//  END_WORD      16'hFFFF               end-of-table token
//  DELAY_TAG     8'hFE                  upper byte marking a delay entry
//  DELAY_CYCLES  1000                   clk_i cycles per delay unit
//  AUTO_START    1                      1: start sequencing on first cycle after reset release
// PORTS
//  clk_i          in   1          clock (I2C clock domain)
//  arstn_i        in   1          async active-low reset
//  start_i        in   1          1-cycle pulse; start/restart sequence from entry 0
//  m_axis_tdata   out  MEM_WIDTH  config word {reg_addr[15:8], reg_data[7:0]}
//  m_axis_tvalid  out  1          beat valid
//  m_axis_tready  in   1          downstream accept
//  busy_o         out  1          sequence in progress
//  done_o         out  1          sequence complete (sticky until next start)
//  words_sent_o   out  8          count of beats accepted this run (saturates at 255)
// BEHAVIOUR
//  - Reset: one clock clk_i; asynchronous, active-low reset arstn_i.
//    All outputs 0, state IDLE, address 0, delay counter 0.
//  - ROM read is registered: 1-cycle latency from address to word.
//  - States:
//    IDLE   -> FETCH on start_i, or on the first cycle after reset when AUTO_START=1.
//    FETCH  drives addr; -> DECODE.
//    DECODE -> DONE if word==END_WORD.
//           -> DELAY if word[15:8]==DELAY_TAG; counter = word[7:0]*DELAY_CYCLES.
//              If word[7:0]==0: advance addr, -> FETCH instead.
//           -> otherwise latch tdata, tvalid<=1, -> SEND.
//    SEND   holds tdata/tvalid stable until tvalid&&tready. On accept: tvalid<=0,
//           words_sent++, addr++, then -> DONE if addr was MEM_DEPTH-1, else -> FETCH.
//    DELAY  decrements to 0; then addr++ -> FETCH, or -> DONE if last entry.
//    DONE   done_o=1, busy_o=0; start_i -> clear done, words_sent, addr; -> FETCH.
//  - Timing: start_i sampled at edge k -> tvalid high from edge k+3.
//    Back-to-back data entries: 3 cycles minimum from accept to next tvalid.
//  - busy_o = 1 in FETCH/DECODE/SEND/DELAY.
//  - start_i while busy is ignored. tvalid never drops before handshake;
//    tdata never changes while tvalid=1 && tready=0.
//  - Table with no END_WORD: stops after entry MEM_DEPTH-1 (no wrap-around).
//  - Reset mid-SEND/DELAY: tvalid drops immediately (async); no partial beat
//    is replayed until the next start.
//  - Delay arithmetic: 8-bit x DELAY_CYCLES into counter of width
//    $clog2(255*DELAY_CYCLES+1); no overflow.
// TESTING
//  1 ROM {1234,5678,FFFF}, tready=1, AUTO_START=1
//    -> beats 1234,5678 in order; done_o=1; words_sent_o=2.
//  2 Same ROM, tready low 10 cycles on beat 1
//    -> tdata stays 1234, tvalid stays 1 throughout; then 5678 follows.
//  3 ROM {0102,FE03,0304,FFFF}, DELAY_CYCLES=4
//    -> gap from 0102 accept to 0304 tvalid = 12 + 3 cycles; words_sent_o=2.
//  4 ROM of MEM_DEPTH data words, no END_WORD
//    -> exactly MEM_DEPTH beats; done_o=1; no wrap to entry 0.
//  5 arstn_i low during SEND of beat 2
//    -> tvalid=0 same cycle; AUTO_START rerun restarts at entry 0.
//  6 AUTO_START=0: start_i pulse while busy ignored; start_i in DONE
//    -> done_o clears, full sequence replays.

Source files
------------

// File: rtl/axis_i2c_cfg_seq_if.sv
// AXI-Stream beat channel between the configuration sequencer and the I2C master.
// The sequencer drives tdata/tvalid and the downstream master returns tready.
interface axis_i2c_cfg_seq_if #(
   parameter int DATA_W = 16
) ();
   logic [DATA_W-1:0] tdata;
   logic              tvalid;
   logic              tready;

   modport master (output tdata, output tvalid, input tready);
   modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_i2c_cfg_seq.sv
// Configuration sequencer: walks a table of {reg_addr, reg_data} words and streams
// each data entry as one AXI-Stream beat, honouring in-band delay and end tokens.
module axis_i2c_cfg_seq #(
   parameter int                             MEM_WIDTH    = 16,
   parameter int                             MEM_DEPTH    = 24,
   parameter logic [MEM_DEPTH*MEM_WIDTH-1:0] ROM_IMAGE    = '1,
   parameter logic [MEM_WIDTH-1:0]           END_WORD     = 16'hFFFF,
   parameter logic [7:0]                     DELAY_TAG    = 8'hFE,
   parameter int                             DELAY_CYCLES = 1000,
   parameter bit                             AUTO_START   = 1'b1
) (
   input  logic                      clk_i,
   input  logic                      arstn_i,
   input  logic                      start_i,
   axis_i2c_cfg_seq_if.master        m_axis,
   output logic                      busy_o,
   output logic                      done_o,
   output logic [7:0]                words_sent_o
);

   localparam int ADDR_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam int CNT_W  = $clog2(255 * DELAY_CYCLES + 1);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);
   // The delay entry's own FETCH and DECODE cycles count toward its delay, so a
   // token of N units stretches the stream by exactly N*DELAY_CYCLES cycles.
   localparam logic [CNT_W-1:0]  DELAY_EXIT = CNT_W'(3);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_FETCH  = 3'd1;
   localparam logic [2:0] S_DECODE = 3'd2;
   localparam logic [2:0] S_SEND   = 3'd3;
   localparam logic [2:0] S_DELAY  = 3'd4;
   localparam logic [2:0] S_DONE   = 3'd5;

   logic [2:0]           state_q,  state_d;
   logic [ADDR_W-1:0]    addr_q,   addr_d;
   logic [CNT_W-1:0]     cnt_q,    cnt_d;
   logic [MEM_WIDTH-1:0] tdata_q,  tdata_d;
   logic                 tvalid_q, tvalid_d;
   logic [7:0]           words_q,  words_d;
   logic [MEM_WIDTH-1:0] rom_q;

   logic [7:0]           word_hi;
   logic [7:0]           word_lo;
   logic                 at_last;
   logic [2:0]           adv_state;
   logic [ADDR_W-1:0]    adv_addr;

   // Entry i lives at ROM_IMAGE[i*MEM_WIDTH +: MEM_WIDTH]; out-of-range reads end the table.
   function automatic logic [MEM_WIDTH-1:0] rom_word(input logic [ADDR_W-1:0] a);
      if (int'(a) < MEM_DEPTH) begin
         return ROM_IMAGE[int'(a)*MEM_WIDTH +: MEM_WIDTH];
      end
      return END_WORD;
   endfunction

   function automatic logic [CNT_W-1:0] delay_count(input logic [7:0] units);
      return CNT_W'(units) * CNT_W'(DELAY_CYCLES);
   endfunction

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   always_ff @(posedge clk_i) begin
      rom_q <= rom_word(addr_q);
   end

   assign word_hi   = rom_q[MEM_WIDTH-1 -: 8];
   assign word_lo   = rom_q[7:0];
   assign at_last   = (addr_q == LAST_ADDR);
   assign adv_state = at_last ? S_DONE : S_FETCH;
   assign adv_addr  = at_last ? addr_q : addr_q + ADDR_W'(1);

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      cnt_d    = cnt_q;
      tdata_d  = tdata_q;
      tvalid_d = tvalid_q;
      words_d  = words_q;

      case (state_q)
         S_IDLE: begin
            if (AUTO_START || start_i) begin
               state_d = S_FETCH;
               addr_d  = '0;
               words_d = '0;
            end
         end
         S_FETCH: begin
            state_d = S_DECODE;
         end
         S_DECODE: begin
            if (rom_q == END_WORD) begin
               state_d = S_DONE;
            end else if (word_hi == DELAY_TAG) begin
               if (word_lo == 8'd0) begin
                  state_d = adv_state;
                  addr_d  = adv_addr;
               end else begin
                  cnt_d   = delay_count(word_lo);
                  state_d = S_DELAY;
               end
            end else begin
               tdata_d  = rom_q;
               tvalid_d = 1'b1;
               state_d  = S_SEND;
            end
         end
         S_SEND: begin
            if (m_axis.tready) begin
               tvalid_d = 1'b0;
               words_d  = sat_inc8(words_q);
               state_d  = adv_state;
               addr_d   = adv_addr;
            end
         end
         S_DELAY: begin
            if (cnt_q <= DELAY_EXIT) begin
               cnt_d   = '0;
               state_d = adv_state;
               addr_d  = adv_addr;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_DONE: begin
            if (start_i) begin
               state_d = S_FETCH;
               addr_d  = '0;
               words_d = '0;
            end
         end
         default: begin
            state_d  = S_IDLE;
            tvalid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         state_q  <= S_IDLE;
         addr_q   <= '0;
         cnt_q    <= '0;
         tdata_q  <= '0;
         tvalid_q <= 1'b0;
         words_q  <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         cnt_q    <= cnt_d;
         tdata_q  <= tdata_d;
         tvalid_q <= tvalid_d;
         words_q  <= words_d;
      end
   end

   assign m_axis.tdata  = tdata_q;
   assign m_axis.tvalid = tvalid_q;
   assign words_sent_o  = words_q;
   assign done_o        = (state_q == S_DONE);
   assign busy_o        = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                          (state_q == S_SEND)  || (state_q == S_DELAY);

   // A stalled beat must stay valid and unchanged until it is accepted.
   a_stall_hold: assert property (@(posedge clk_i) disable iff (!arstn_i)
      (m_axis.tvalid && !m_axis.tready) |=> (m_axis.tvalid && $stable(m_axis.tdata)));

endmodule

// File: tb/tb_axis_i2c_cfg_seq.sv
// Directed bench for axis_i2c_cfg_seq: four instances cover the basic table, delay
// tokens, a full table without end token, and manual start.
module tb_axis_i2c_cfg_seq;
   localparam int W = 16;
   localparam int D = 24;

   function automatic logic [15:0] exp_c(input int i);
      return {8'(i + 1), 8'(i * 3)};
   endfunction

   function automatic logic [D*W-1:0] mk_rom_c();
      logic [D*W-1:0] r;
      r = '0;
      for (int i = 0; i < D; i++) r[i*W +: W] = exp_c(i);
      return r;
   endfunction

   localparam logic [D*W-1:0] ROM_A = {{21{16'hFFFF}}, 16'hFFFF, 16'h5678, 16'h1234};
   localparam logic [D*W-1:0] ROM_B = {{18{16'hFFFF}}, 16'hFFFF, 16'h0506, 16'hFE00,
                                       16'h0304, 16'hFE03, 16'h0102};
   localparam logic [D*W-1:0] ROM_C = mk_rom_c();

   logic       clk   = 1'b0;
   logic       arstn = 1'b0;
   logic       start = 1'b0;
   logic       busy_a, done_a, busy_b, done_b, busy_c, done_c, busy_d, done_d;
   logic [7:0] ws_a, ws_b, ws_c, ws_d;

   int n_checks = 0;
   int n_fail   = 0;

   axis_i2c_cfg_seq_if #(.DATA_W(W)) ifa ();
   axis_i2c_cfg_seq_if #(.DATA_W(W)) ifb ();
   axis_i2c_cfg_seq_if #(.DATA_W(W)) ifc ();
   axis_i2c_cfg_seq_if #(.DATA_W(W)) ifd ();

   axis_i2c_cfg_seq #(.MEM_WIDTH(W), .MEM_DEPTH(D), .ROM_IMAGE(ROM_A)) dut_a (
      .clk_i(clk), .arstn_i(arstn), .start_i(start), .m_axis(ifa),
      .busy_o(busy_a), .done_o(done_a), .words_sent_o(ws_a));

   axis_i2c_cfg_seq #(.MEM_WIDTH(W), .MEM_DEPTH(D), .ROM_IMAGE(ROM_B),
                      .DELAY_CYCLES(4)) dut_b (
      .clk_i(clk), .arstn_i(arstn), .start_i(start), .m_axis(ifb),
      .busy_o(busy_b), .done_o(done_b), .words_sent_o(ws_b));

   axis_i2c_cfg_seq #(.MEM_WIDTH(W), .MEM_DEPTH(D), .ROM_IMAGE(ROM_C)) dut_c (
      .clk_i(clk), .arstn_i(arstn), .start_i(start), .m_axis(ifc),
      .busy_o(busy_c), .done_o(done_c), .words_sent_o(ws_c));

   axis_i2c_cfg_seq #(.MEM_WIDTH(W), .MEM_DEPTH(D), .ROM_IMAGE(ROM_A),
                      .AUTO_START(1'b0)) dut_d (
      .clk_i(clk), .arstn_i(arstn), .start_i(start), .m_axis(ifd),
      .busy_o(busy_d), .done_o(done_d), .words_sent_o(ws_d));

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reset is released 1 time unit after an edge; the next edge is "first cycle after reset".
   task automatic apply_reset();
      arstn = 1'b0;
      start = 1'b0;
      repeat (2) tick();
      arstn = 1'b1;
   endtask

   task automatic test_reset();
      arstn = 1'b0;
      repeat (2) tick();
      n_checks++;
      if ({ifa.tvalid, busy_a, done_a} !== 3'b000 || ifa.tdata !== 16'h0000 || ws_a !== 8'd0) begin
         n_fail++;
         $display("FAIL reset_outputs_a: tvalid=%b busy=%b done=%b tdata=%h ws=%0d, required all 0",
                  ifa.tvalid, busy_a, done_a, ifa.tdata, ws_a);
      end
      n_checks++;
      if ({ifd.tvalid, busy_d, done_d} !== 3'b000 || ws_d !== 8'd0) begin
         n_fail++;
         $display("FAIL reset_outputs_d: tvalid=%b busy=%b done=%b ws=%0d, required all 0",
                  ifd.tvalid, busy_d, done_d, ws_d);
      end
      arstn = 1'b1;
      repeat (5) tick();
      n_checks++;
      if ({ifd.tvalid, busy_d, done_d} !== 3'b000) begin
         n_fail++;
         $display("FAIL idle_without_autostart: tvalid=%b busy=%b done=%b, required 000",
                  ifd.tvalid, busy_d, done_d);
      end
   endtask

   task automatic test_basic();
      logic [15:0] beats [4];
      int          acc [4];
      int          rise [4];
      int          nb;
      int          stay;
      logic        prev_v;
      nb = 0;
      prev_v = 1'b0;
      for (int k = 0; k < 4; k++) begin beats[k] = '0; acc[k] = -1; rise[k] = -1; end
      ifa.tready = 1'b1;
      apply_reset();
      for (int t = 1; t <= 60; t++) begin
         tick();
         if (ifa.tvalid && !prev_v && nb < 4) rise[nb] = t;
         prev_v = ifa.tvalid;
         if (ifa.tvalid && ifa.tready && nb < 4) begin
            beats[nb] = ifa.tdata; acc[nb] = t; nb++;
         end
         if (done_a) break;
      end
      n_checks++;
      if (rise[0] !== 3) begin
         n_fail++;
         $display("FAIL basic_start_latency: first tvalid at edge %0d, required 3", rise[0]);
      end
      n_checks++;
      if (nb !== 2) begin
         n_fail++;
         $display("FAIL basic_beat_count: got %0d, required 2", nb);
      end
      n_checks++;
      if (beats[0] !== 16'h1234 || beats[1] !== 16'h5678) begin
         n_fail++;
         $display("FAIL basic_beat_data: got %h %h, required 1234 5678", beats[0], beats[1]);
      end
      n_checks++;
      if (rise[1] - acc[0] !== 3) begin
         n_fail++;
         $display("FAIL basic_b2b_gap: got %0d, required 3", rise[1] - acc[0]);
      end
      n_checks++;
      if ({done_a, busy_a} !== 2'b10 || ws_a !== 8'd2) begin
         n_fail++;
         $display("FAIL basic_done: done=%b busy=%b ws=%0d, required done=1 busy=0 ws=2",
                  done_a, busy_a, ws_a);
      end
      stay = 0;
      repeat (5) begin
         tick();
         if (done_a && !ifa.tvalid) stay++;
      end
      n_checks++;
      if (stay !== 5) begin
         n_fail++;
         $display("FAIL basic_done_sticky: held for %0d of 5 cycles", stay);
      end
   endtask

   task automatic test_backpressure();
      logic [15:0] beats [4];
      int          nb;
      int          holds;
      nb = 0;
      holds = 0;
      for (int k = 0; k < 4; k++) beats[k] = '0;
      ifa.tready = 1'b0;
      apply_reset();
      for (int t = 0; t < 20; t++) begin
         tick();
         if (ifa.tvalid) break;
      end
      for (int t = 0; t < 10; t++) begin
         tick();
         if (ifa.tvalid === 1'b1 && ifa.tdata === 16'h1234) holds++;
      end
      n_checks++;
      if (holds !== 10) begin
         n_fail++;
         $display("FAIL stall_hold: beat held for %0d of 10 cycles, required 10", holds);
      end
      ifa.tready = 1'b1;
      for (int t = 0; t < 40; t++) begin
         if (ifa.tvalid && ifa.tready && nb < 4) begin beats[nb] = ifa.tdata; nb++; end
         if (done_a) break;
         tick();
      end
      n_checks++;
      if (nb !== 2 || beats[0] !== 16'h1234 || beats[1] !== 16'h5678 || ws_a !== 8'd2) begin
         n_fail++;
         $display("FAIL stall_release: n=%0d beats %h %h ws=%0d, required 2 beats 1234 5678 ws=2",
                  nb, beats[0], beats[1], ws_a);
      end
   endtask

   task automatic test_delay();
      logic [15:0] beats [4];
      int          acc [4];
      int          rise [4];
      int          nb;
      logic        prev_v;
      nb = 0;
      prev_v = 1'b0;
      for (int k = 0; k < 4; k++) begin beats[k] = '0; acc[k] = -1; rise[k] = -1; end
      ifb.tready = 1'b1;
      apply_reset();
      for (int t = 1; t <= 100; t++) begin
         tick();
         if (ifb.tvalid && !prev_v && nb < 4) rise[nb] = t;
         prev_v = ifb.tvalid;
         if (ifb.tvalid && ifb.tready && nb < 4) begin
            beats[nb] = ifb.tdata; acc[nb] = t; nb++;
         end
         if (done_b) break;
      end
      n_checks++;
      if (nb !== 3 || beats[0] !== 16'h0102 || beats[1] !== 16'h0304 || beats[2] !== 16'h0506) begin
         n_fail++;
         $display("FAIL delay_beats: n=%0d %h %h %h, required 3 beats 0102 0304 0506",
                  nb, beats[0], beats[1], beats[2]);
      end
      // 3 delay units x 4 cycles on top of the 3-cycle back-to-back gap.
      n_checks++;
      if (rise[1] - acc[0] !== 15) begin
         n_fail++;
         $display("FAIL delay_gap: got %0d, required 15", rise[1] - acc[0]);
      end
      // Zero-unit delay token costs only its own fetch and decode.
      n_checks++;
      if (rise[2] - acc[1] !== 5) begin
         n_fail++;
         $display("FAIL zero_delay_gap: got %0d, required 5", rise[2] - acc[1]);
      end
      n_checks++;
      if (done_b !== 1'b1 || ws_b !== 8'd3) begin
         n_fail++;
         $display("FAIL delay_done: done=%b ws=%0d, required done=1 ws=3", done_b, ws_b);
      end
   endtask

   task automatic test_no_end();
      int nb;
      int bad;
      int late;
      nb = 0;
      bad = 0;
      late = 0;
      ifc.tready = 1'b1;
      apply_reset();
      for (int t = 0; t < 200; t++) begin
         tick();
         if (ifc.tvalid && ifc.tready) begin
            if (ifc.tdata !== exp_c(nb)) bad++;
            nb++;
         end
         if (done_c) break;
      end
      n_checks++;
      if (nb !== D) begin
         n_fail++;
         $display("FAIL full_table_count: got %0d beats, required %0d", nb, D);
      end
      n_checks++;
      if (bad !== 0) begin
         n_fail++;
         $display("FAIL full_table_data: %0d beats differ from table, required 0", bad);
      end
      n_checks++;
      if (done_c !== 1'b1 || ws_c !== 8'(D)) begin
         n_fail++;
         $display("FAIL full_table_done: done=%b ws=%0d, required done=1 ws=%0d", done_c, ws_c, D);
      end
      repeat (10) begin
         tick();
         if (ifc.tvalid || !done_c) late++;
      end
      n_checks++;
      if (late !== 0) begin
         n_fail++;
         $display("FAIL full_table_no_wrap: %0d cycles with activity after done, required 0", late);
      end
   endtask

   task automatic test_reset_mid_send();
      logic [15:0] beats [4];
      int          nb;
      nb = 0;
      for (int k = 0; k < 4; k++) beats[k] = '0;
      ifa.tready = 1'b1;
      apply_reset();
      for (int t = 0; t < 20; t++) begin
         tick();
         if (ifa.tvalid) break;
      end
      tick();
      ifa.tready = 1'b0;
      for (int t = 0; t < 20; t++) begin
         tick();
         if (ifa.tvalid) break;
      end
      repeat (2) tick();
      n_checks++;
      if (ifa.tvalid !== 1'b1 || ifa.tdata !== 16'h5678 || ws_a !== 8'd1) begin
         n_fail++;
         $display("FAIL rst_pre_state: tvalid=%b tdata=%h ws=%0d, required 1 5678 1",
                  ifa.tvalid, ifa.tdata, ws_a);
      end
      arstn = 1'b0;
      #1;
      n_checks++;
      if ({ifa.tvalid, busy_a, done_a} !== 3'b000 || ws_a !== 8'd0) begin
         n_fail++;
         $display("FAIL rst_async_drop: tvalid=%b busy=%b done=%b ws=%0d, required all 0",
                  ifa.tvalid, busy_a, done_a, ws_a);
      end
      tick();
      arstn = 1'b1;
      ifa.tready = 1'b1;
      for (int t = 0; t < 60; t++) begin
         tick();
         if (ifa.tvalid && ifa.tready && nb < 4) begin beats[nb] = ifa.tdata; nb++; end
         if (done_a) break;
      end
      n_checks++;
      if (nb !== 2 || beats[0] !== 16'h1234 || beats[1] !== 16'h5678 || ws_a !== 8'd2) begin
         n_fail++;
         $display("FAIL rst_rerun: n=%0d beats %h %h ws=%0d, required 2 beats 1234 5678 ws=2",
                  nb, beats[0], beats[1], ws_a);
      end
   endtask

   task automatic test_manual_start();
      logic [15:0] beats [4];
      int          nb;
      logic        v1;
      for (int k = 0; k < 4; k++) beats[k] = '0;
      ifd.tready = 1'b1;
      apply_reset();
      repeat (5) tick();
      n_checks++;
      if ({ifd.tvalid, busy_d, done_d} !== 3'b000) begin
         n_fail++;
         $display("FAIL manual_idle: tvalid=%b busy=%b done=%b, required 000",
                  ifd.tvalid, busy_d, done_d);
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      n_checks++;
      if (busy_d !== 1'b1) begin
         n_fail++;
         $display("FAIL manual_busy: busy=%b, required 1", busy_d);
      end
      tick();
      v1 = ifd.tvalid;
      tick();
      n_checks++;
      if ({v1, ifd.tvalid} !== 2'b01 || ifd.tdata !== 16'h1234) begin
         n_fail++;
         $display("FAIL manual_start_latency: tvalid k+2/k+3=%b%b tdata=%h, required 01 1234",
                  v1, ifd.tvalid, ifd.tdata);
      end
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      nb = 0;
      for (int t = 0; t < 40; t++) begin
         if (ifd.tvalid && ifd.tready && nb < 4) begin beats[nb] = ifd.tdata; nb++; end
         if (done_d) break;
         tick();
      end
      n_checks++;
      if (nb !== 1 || beats[0] !== 16'h5678 || ws_d !== 8'd2 || done_d !== 1'b1) begin
         n_fail++;
         $display("FAIL start_while_busy: n=%0d first=%h ws=%0d done=%b, required 1 5678 2 1",
                  nb, beats[0], ws_d, done_d);
      end
      repeat (3) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      n_checks++;
      if ({done_d, busy_d} !== 2'b01 || ws_d !== 8'd0) begin
         n_fail++;
         $display("FAIL restart_from_done: done=%b busy=%b ws=%0d, required done=0 busy=1 ws=0",
                  done_d, busy_d, ws_d);
      end
      nb = 0;
      for (int k = 0; k < 4; k++) beats[k] = '0;
      for (int t = 0; t < 40; t++) begin
         if (ifd.tvalid && ifd.tready && nb < 4) begin beats[nb] = ifd.tdata; nb++; end
         if (done_d) break;
         tick();
      end
      n_checks++;
      if (nb !== 2 || beats[0] !== 16'h1234 || beats[1] !== 16'h5678 || ws_d !== 8'd2) begin
         n_fail++;
         $display("FAIL replay: n=%0d beats %h %h ws=%0d, required 2 beats 1234 5678 ws=2",
                  nb, beats[0], beats[1], ws_d);
      end
   endtask

   initial begin
      ifa.tready = 1'b1;
      ifb.tready = 1'b1;
      ifc.tready = 1'b1;
      ifd.tready = 1'b1;
      test_reset();
      test_basic();
      test_backpressure();
      test_delay();
      test_no_end();
      test_reset_mid_send();
      test_manual_start();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end
endmodule
